// File: rtl/n_bit_adder.sv
// Ripple-free behavioural W-bit adder with carry-in and carry-out.
// Shared arithmetic building block; 'of' is the carry out of the top bit.
module n_bit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         of
);

    assign {of, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/n_bit_divider_seq.sv
// Sequential unsigned N-bit restoring divider, one quotient bit per clock.
// Handshake: start is taken only while busy=0; done pulses for one cycle with results.
module n_bit_divider_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t state_q, state_d;

    logic [N-1:0]     q_reg;
    logic [N-1:0]     d_reg;
    // Restored R always fits in N bits; the extra bit only exists inside a step.
    logic [N-1:0]     r_reg;
    logic [CNT_W-1:0] cnt_q;

    logic [N:0]   step_t;
    logic [N:0]   step_diff;
    logic         step_ge;
    logic [N:0]   step_r;
    logic [N-1:0] step_q;
    logic         r_msb_unused;
    logic         accept;
    logic         last_step;

    // T - {0,D} as T + ~{0,D} + 1; carry out set means T >= D.
    n_bit_adder #(.W(N + 1)) u_sub (
        .a   (step_t),
        .b   (~{1'b0, d_reg}),
        .cin (1'b1),
        .sum (step_diff),
        .of  (step_ge)
    );

    always_comb begin
        step_t       = {r_reg, q_reg[N-1]};
        step_r       = step_ge ? step_diff : step_t;
        step_q       = {q_reg[N-2:0], step_ge};
        r_msb_unused = step_r[N];
        accept       = (state_q == IDLE) && start;
        last_step    = (state_q == RUN) && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (divisor == '0) ? DONE : RUN;
            RUN:  if (cnt_q == CNT_LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            q_reg <= step_q;
            r_reg <= step_r[N-1:0];
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Result registers change only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && (divisor == '0)) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last_step) begin
            quotient    <= step_q;
            remainder   <= step_r[N-1:0];
            div_by_zero <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_n_bit_divider_seq.sv
// Scoreboard bench for n_bit_divider_seq: driver pushes model results, monitor pops on done.
module tb_n_bit_divider_seq;

    localparam int N = 4;
    localparam int W = 2 * N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    logic [W-1:0]   exp_q[$];
    int             lat_q[$];
    int             iss_q[$];
    logic [2*N-1:0] opr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    n_bit_divider_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain integer division; divide by zero gives all ones, remainder = dividend.
    function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] ones;
        ones = '1;
        if (b == 0) return {1'b1, ones, a};
        return {1'b0, N'(a / b), N'(a % b)};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic expect_result(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_q.push_back(model(a, b));
        lat_q.push_back((b == 0) ? 1 : N + 1);
        iss_q.push_back(cyc);
        opr_q.push_back({a, b});
    endtask

    // Called at a falling edge; returns at a falling edge with start low.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        expect_result(a, b);
        @(negedge clk);
        start    = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    task automatic held_start_test();
        int n = 0;
        wait_idle();
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        expect_result(4'd13, 4'd3);
        @(negedge clk);
        dividend = 4'd8;
        divisor  = 4'd2;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("held_busy_drop", 32'(busy), 32'd0);
        expect_result(4'd8, 4'd2);
        @(negedge clk);
        start = 1'b0;
        check("held_second_busy", 32'(busy), 32'd1);
    endtask

    task automatic reset_abort_test();
        wait_idle();
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per done pulse.
    logic [W-1:0]   m_exp;
    logic [2*N-1:0] m_ops;
    int             m_lat;
    int             m_iss;

    always begin
        @(posedge clk);
        #1;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 want=0 (cycle %0d)", cyc);
            end else begin
                m_exp = exp_q.pop_front();
                m_lat = lat_q.pop_front();
                m_iss = iss_q.pop_front();
                m_ops = opr_q.pop_front();
                check("quotient", 32'(quotient), 32'(m_exp[2*N-1:N]));
                check("remainder", 32'(remainder), 32'(m_exp[N-1:0]));
                check("div_by_zero", 32'(div_by_zero), 32'(m_exp[2*N]));
                check("latency", 32'(cyc - m_iss), 32'(m_lat));
                check("busy_in_done", 32'(busy), 32'd1);
                if (m_ops[N-1:0] != 0) begin
                    check("identity", 32'(int'(quotient) * int'(m_ops[N-1:0]) + int'(remainder)),
                          32'(m_ops[2*N-1:N]));
                    check("rem_lt_div", 32'(remainder < m_ops[N-1:0]), 32'd1);
                end
            end
        end
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(4'd13, 4'd3);
        issue(4'd15, 4'd1);
        issue(4'd15, 4'd15);
        issue(4'd0, 4'd7);
        issue(4'd5, 4'd9);
        issue(4'd9, 4'd0);
        issue(4'd6, 4'd2);
        held_start_test();
        issue(4'd11, 4'd4);
        reset_abort_test();
        issue(4'd12, 4'd5);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(N'($urandom), N'($urandom_range(0, 15)));
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(N'(a), N'(b));
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
